// File: rtl/uart_inst_parser_if.sv
// Handshake bundle between the UART receive path, the instruction parser and the sequencer.
// The parser sits on the slave side; the host/driver environment uses master.
interface uart_inst_parser_if #(
  parameter int FIFO_AW = 2
);
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             i_hold;
  logic             i_clr;
  logic [7:0]       o_inst;
  logic             o_inst_valid;
  logic [FIFO_AW:0] o_fifo_level;
  logic             o_overflow;
  logic [7:0]       o_err_cnt;

  modport master (
    output i_rx_data, i_rx_valid, i_hold, i_clr,
    input  o_inst, o_inst_valid, o_fifo_level, o_overflow, o_err_cnt
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_hold, i_clr,
    output o_inst, o_inst_valid, o_fifo_level, o_overflow, o_err_cnt
  );
endinterface

// File: rtl/uart_inst_parser.sv
// Parses ASCII hex instruction lines ("3A\r") from the UART receiver, buffers them in a
// small FIFO and issues them to the sequencer as spaced single-cycle strobes.
module uart_inst_parser #(
  parameter int FIFO_AW   = 2,
  parameter int ISSUE_GAP = 16
) (
  input logic         clk,
  input logic         arst_i,
  uart_inst_parser_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_ERR} state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  // Letters A-F/a-f have 1..6 in the low nibble, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_t           state, state_nx;
  logic             push_req, err_inc, latch_hi, latch_lo;
  logic             rx_hex, rx_term;
  logic [3:0]       hi_nib, lo_nib;

  logic             push_p1;
  logic [7:0]       push_byte_p1;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level;
  logic [GAP_W-1:0] gap;
  logic             pop, push_ok, fifo_full;
  logic [7:0]       inst;
  logic             inst_valid, overflow;
  logic [7:0]       err_cnt;

  assign rx_hex  = is_hex(bus.i_rx_data);
  assign rx_term = is_term(bus.i_rx_data);

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push_req = 1'b0;
    err_inc  = 1'b0;
    latch_hi = 1'b0;
    latch_lo = 1'b0;
    if (bus.i_rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (rx_hex) begin
            latch_hi = 1'b1;
            state_nx = S_HI;
          end else if (!rx_term) begin
            state_nx = S_ERR;
          end
        end
        S_HI: begin
          if (rx_hex) begin
            latch_lo = 1'b1;
            state_nx = S_LO;
          end else if (rx_term) begin
            err_inc  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_ERR;
          end
        end
        S_LO: begin
          if (rx_term) begin
            push_req = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_ERR;
          end
        end
        S_ERR: begin
          if (rx_term) begin
            err_inc  = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (latch_hi) hi_nib <= hex_val(bus.i_rx_data);
    if (latch_lo) lo_nib <= hex_val(bus.i_rx_data);
  end

  // ---- stage p1: completed line waits one cycle before entering the FIFO ----
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) push_p1 <= 1'b0;
    else        push_p1 <= push_req;
  end

  always_ff @(posedge clk) begin
    if (push_req) push_byte_p1 <= {hi_nib, lo_nib};
  end

  // ---- FIFO and issue: a pop in the same cycle frees the slot a full FIFO needs ----
  assign fifo_full = (level == LEVEL_FULL);
  assign pop       = (level != '0) && !bus.i_hold && (gap == '0);
  assign push_ok   = push_p1 && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte_p1;
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      gap        <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      overflow   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      inst_valid <= pop;
      if (pop) begin
        inst <= mem[rd_ptr];
        gap  <= GAP_RELOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end

      if (bus.i_clr)                          overflow <= 1'b0;
      else if (push_p1 && fifo_full && !pop)  overflow <= 1'b1;

      if (bus.i_clr)    err_cnt <= '0;
      else if (err_inc) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign bus.o_inst       = inst;
  assign bus.o_inst_valid = inst_valid;
  assign bus.o_fifo_level = level;
  assign bus.o_overflow   = overflow;
  assign bus.o_err_cnt    = err_cnt;

endmodule
